df_axil_write_sequencer: RTL and testbench

- Downstream stage of the dataflow controller's register file.
- On a start pulse, snapshots a block of N_REGS 32-bit control words and writes them over an AXI-Lite master into the accelerator's (SAURIA) config space, one register at a time.
- Then writes the accelerator's start bit and waits for its completion interrupt.
- Reports done/error back to the controller, which sets its done/interrupt status bits.

---
 rtl/df_ctrl_pkg.sv | 20 ++
 rtl/axil_single_write.sv | 63 ++++++
 rtl/df_axil_write_sequencer.sv | 141 ++++++++++++++
 tb/tb_df_axil_write_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/df_ctrl_pkg.sv
// Shared types and constants for the dataflow controller and its SAURIA
// configuration write sequencer.
package df_ctrl_pkg;

  localparam int SAURIA_NARGS = 8;

  localparam logic [1:0]  AXI_RESP_OKAY         = 2'b00;
  localparam int          SAURIA_CTRL_START_BIT = 0;
  localparam logic [31:0] SAURIA_REG_OFFSET     = 32'h10;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_ADDR,
    SEQ_RESP,
    SEQ_KICK,
    SEQ_KRESP,
    SEQ_WAIT_IRQ
  } seq_state_e;

endpackage

// File: rtl/axil_single_write.sv
// Issues one AXI-Lite AW+W pair while req is high and forwards the B response
// while resp_req is high.
module axil_single_write #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data,
  input  logic                  resp_req,
  output logic                  ack,
  output logic                  resp_valid,
  output logic [1:0]            resp,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready
);

  // Handshake rule: a valid stays high until the cycle its ready is also
  // high; the transfer happens on that edge and the valid drops afterwards.
  logic aw_done, w_done;
  logic aw_hs, w_hs;

  assign m_awvalid = req & ~aw_done;
  assign m_wvalid  = req & ~w_done;
  assign m_awaddr  = addr;
  assign m_awprot  = 3'b000;
  assign m_wdata   = data;
  assign m_wstrb   = 4'hF;

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;

  // ack fires in the cycle the later of the two handshakes completes.
  assign ack = req & (aw_done | aw_hs) & (w_done | w_hs);

  assign m_bready   = resp_req;
  assign resp_valid = resp_req & m_bvalid;
  assign resp       = m_bresp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (ack) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

endmodule

// File: rtl/df_axil_write_sequencer.sv
// Snapshots N_REGS control words, writes them to the SAURIA config space over
// AXI-Lite, kicks the start bit and waits for the completion interrupt.
module df_axil_write_sequencer
  import df_ctrl_pkg::*;
#(
  parameter int                    N_REGS      = SAURIA_NARGS * 2,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_WIDTH-1:0] REG_OFFSET  = ADDR_WIDTH'(SAURIA_REG_OFFSET),
  parameter logic [ADDR_WIDTH-1:0] CTRL_OFFSET = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [N_REGS*32-1:0]  regs_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic                  irq_i,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [31:0]           m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output seq_state_e            dbg_state
);

  localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  seq_state_e              state, state_next;
  logic [IDX_W-1:0]        idx;
  logic [N_REGS-1:0][31:0] snapshot;
  logic                    irq_prev, irq_latch, irq_edge, irq_window;
  logic                    accept, finish, last_reg;
  logic                    wr_req, wr_ack, resp_req, resp_valid;
  logic [1:0]              resp;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [31:0]             wr_data;
  logic                    read_unused;

  assign m_araddr    = '0;
  assign m_arprot    = 3'b000;
  assign m_arvalid   = 1'b0;
  assign m_rready    = 1'b1;
  assign read_unused = ^{m_arready, m_rdata, m_rresp, m_rvalid};
  assign dbg_state   = state;

  assign last_reg   = (idx == IDX_W'(N_REGS - 1));
  assign accept     = (state == SEQ_IDLE) & start_i & ~done_o;
  assign irq_edge   = irq_i & ~irq_prev;
  assign irq_window = (state == SEQ_KICK) | (state == SEQ_KRESP) | (state == SEQ_WAIT_IRQ);
  assign finish     = (state == SEQ_WAIT_IRQ) & (irq_latch | irq_edge);

  assign wr_req   = (state == SEQ_ADDR) | (state == SEQ_KICK);
  assign resp_req = (state == SEQ_RESP) | (state == SEQ_KRESP);
  assign wr_addr  = (state == SEQ_KICK) ? (BASE_ADDR + CTRL_OFFSET)
                                        : (BASE_ADDR + REG_OFFSET + ADDR_WIDTH'({idx, 2'b00}));
  assign wr_data  = (state == SEQ_KICK) ? (32'h1 << SAURIA_CTRL_START_BIT) : snapshot[idx];

  axil_single_write #(.ADDR_WIDTH(ADDR_WIDTH)) u_write (
    .clk        (clk),
    .rst        (rst),
    .req        (wr_req),
    .addr       (wr_addr),
    .data       (wr_data),
    .resp_req   (resp_req),
    .ack        (wr_ack),
    .resp_valid (resp_valid),
    .resp       (resp),
    .m_awaddr   (m_awaddr),
    .m_awprot   (m_awprot),
    .m_awvalid  (m_awvalid),
    .m_awready  (m_awready),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_wvalid   (m_wvalid),
    .m_wready   (m_wready),
    .m_bresp    (m_bresp),
    .m_bvalid   (m_bvalid),
    .m_bready   (m_bready)
  );

  always_comb begin
    state_next = state;
    case (state)
      SEQ_IDLE:     if (accept) state_next = SEQ_ADDR;
      SEQ_ADDR:     if (wr_ack) state_next = SEQ_RESP;
      SEQ_RESP:     if (resp_valid) state_next = last_reg ? SEQ_KICK : SEQ_ADDR;
      SEQ_KICK:     if (wr_ack) state_next = SEQ_KRESP;
      SEQ_KRESP:    if (resp_valid) state_next = SEQ_WAIT_IRQ;
      SEQ_WAIT_IRQ: if (finish) state_next = SEQ_IDLE;
      default:      state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEQ_IDLE;
      idx       <= '0;
      snapshot  <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      irq_prev  <= 1'b0;
      irq_latch <= 1'b0;
    end else begin
      state    <= state_next;
      irq_prev <= irq_i;
      done_o   <= finish;
      if (accept) begin
        snapshot <= regs_i;
        idx      <= '0;
        err_o    <= 1'b0;
        busy_o   <= 1'b1;
      end else if (finish) begin
        busy_o <= 1'b0;
      end
      // Error responses are recorded but never cut the run short.
      if (resp_valid && (resp != AXI_RESP_OKAY)) err_o <= 1'b1;
      if ((state == SEQ_RESP) && resp_valid && !last_reg) idx <= idx + 1'b1;
      // An edge that lands before WAIT_IRQ is held here so it is not lost.
      if (finish) irq_latch <= 1'b0;
      else if (irq_window && irq_edge) irq_latch <= 1'b1;
    end
  end

endmodule

// File: tb/tb_df_axil_write_sequencer.sv
// Randomised bench for df_axil_write_sequencer: an AXI-Lite slave model feeds a
// scoreboard that pairs each AW/W transfer with the expected register write.
module tb_df_axil_write_sequencer;
  import df_ctrl_pkg::*;

  localparam int NR = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start_i = 1'b0;
  logic [NR*32-1:0]  regs_i  = '0;
  logic              busy_o, done_o, err_o;
  logic              irq_i = 1'b0;
  logic [31:0]       m_awaddr;
  logic [2:0]        m_awprot;
  logic              m_awvalid;
  logic              m_awready = 1'b0;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_wvalid;
  logic              m_wready = 1'b0;
  logic [1:0]        m_bresp = 2'b00;
  logic              m_bvalid = 1'b0;
  logic              m_bready;
  logic [31:0]       m_araddr;
  logic [2:0]        m_arprot;
  logic              m_arvalid;
  logic              m_arready = 1'b0;
  logic [31:0]       m_rdata = '0;
  logic [1:0]        m_rresp = 2'b00;
  logic              m_rvalid = 1'b0;
  logic              m_rready;
  seq_state_e        dbg_state;

  df_axil_write_sequencer #(.N_REGS(NR)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .regs_i(regs_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .irq_i(irq_i),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [63:0] exp_q[$];
  logic [31:0] act_aw_q[$];
  logic [31:0] act_w_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int b_cnt = 0;
  int wr_cnt = 0;

  // slave model knobs
  bit rand_mode = 1'b0;
  int aw_hold = 0;
  int w_hold = 0;
  int b_delay = 0;
  int err_at = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // AXI-Lite slave and monitor: drives readies/B at negedge, then records
  // the handshakes that the following posedge will complete.
  bit aw_got, w_got, b_arm, aw_hs_l, w_hs_l, b_hs_l, aw_st_l, w_st_l;
  int b_wait;
  logic [31:0] aw_addr_l, w_data_l;

  always @(negedge clk) begin
    if (rst) begin
      aw_got = 0; w_got = 0; b_arm = 0; b_wait = 0;
      aw_hs_l = 0; w_hs_l = 0; b_hs_l = 0; aw_st_l = 0; w_st_l = 0;
      m_bvalid = 1'b0; m_bresp = 2'b00;
    end else begin
      if (aw_hs_l) chk("awvalid_drop_after_hs", m_awvalid, 0);
      if (w_hs_l)  chk("wvalid_drop_after_hs", m_wvalid, 0);
      if (aw_st_l) begin
        chk("awvalid_held_while_stalled", m_awvalid, 1);
        chk("awaddr_stable_while_stalled", m_awaddr, aw_addr_l);
      end
      if (w_st_l) begin
        chk("wvalid_held_while_stalled", m_wvalid, 1);
        chk("wdata_stable_while_stalled", m_wdata, w_data_l);
      end
      if (b_hs_l) m_bvalid = 1'b0;
      if (aw_hs_l) aw_got = 1;
      if (w_hs_l)  w_got = 1;
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; b_arm = 1; b_wait = b_delay;
      end
      if (b_arm) begin
        if (b_wait == 0) begin
          b_arm = 0;
          m_bvalid = 1'b1;
          m_bresp = (b_cnt == err_at) ? 2'b10 : 2'b00;
        end else begin
          b_wait--;
        end
      end
      if (aw_hold > 0 && m_awvalid) begin
        m_awready = 1'b0; aw_hold--;
      end else begin
        m_awready = rand_mode ? ($urandom_range(0, 99) < 60) : 1'b1;
      end
      if (w_hold > 0 && m_wvalid) begin
        m_wready = 1'b0; w_hold--;
      end else begin
        m_wready = rand_mode ? ($urandom_range(0, 99) < 60) : 1'b1;
      end
      aw_hs_l = m_awvalid && m_awready;
      w_hs_l  = m_wvalid && m_wready;
      b_hs_l  = m_bvalid && m_bready;
      aw_st_l = m_awvalid && !m_awready;
      w_st_l  = m_wvalid && !m_wready;
      aw_addr_l = m_awaddr;
      w_data_l  = m_wdata;
      if (aw_hs_l) begin
        act_aw_q.push_back(m_awaddr);
        chk("awprot", m_awprot, 0);
      end
      if (w_hs_l) begin
        act_w_q.push_back(m_wdata);
        chk("wstrb", m_wstrb, 4'hF);
      end
      if (b_hs_l) b_cnt++;
      while (act_aw_q.size() > 0 && act_w_q.size() > 0) begin
        logic [63:0] act, exp;
        act = {act_aw_q.pop_front(), act_w_q.pop_front()};
        if (exp_q.size() == 0) begin
          chk("unexpected_write", act, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          exp = exp_q.pop_front();
          chk("write_addr_data", act, exp);
        end
        wr_cnt++;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [NR*32-1:0] rand_regs();
    logic [NR*32-1:0] r;
    for (int i = 0; i < NR; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Reference: word i goes to 0x10 + 4*i, then the start bit to 0x0.
  task automatic push_expected(input logic [NR*32-1:0] regs);
    for (int i = 0; i < NR; i++) exp_q.push_back({32'h10 + 32'(4 * i), regs[32*i +: 32]});
    exp_q.push_back({32'h0, 32'h1});
  endtask

  task automatic run(input logic [NR*32-1:0] regs, input int err_a, input int irq_mode,
                     input int b_del, input bit mid_start, input bit done_start);
    logic err_exp;
    int t;
    err_at  = err_a;
    err_exp = (err_a >= 0 && err_a <= NR);
    b_delay = (irq_mode == 1) ? 3 : b_del;
    b_cnt = 0;
    wr_cnt = 0;
    push_expected(regs);
    regs_i = regs;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    regs_i = rand_regs();
    chk("busy_after_start", busy_o, 1);
    chk("err_cleared_on_start", err_o, 0);
    chk("first_awvalid", m_awvalid, 1);
    if (mid_start) begin
      repeat (3) tick();
      regs_i = rand_regs();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("busy_during_restart", busy_o, 1);
    end
    if (irq_mode == 0) begin
      t = 0;
      while (b_cnt < NR + 1 && t < 1000) begin tick(); t++; end
      chk("all_responses_consumed", b_cnt, NR + 1);
      repeat (5) tick();
      irq_i = 1'b1;
      chk("done_before_irq", done_o, 0);
      tick();
      chk("done_after_irq_edge", done_o, 1);
      chk("busy_at_done", busy_o, 0);
      chk("err_at_done", err_o, err_exp);
      if (done_start) begin
        start_i = 1'b1;
        regs_i = rand_regs();
      end
      tick();
      start_i = 1'b0;
      irq_i = 1'b0;
      chk("done_single_cycle", done_o, 0);
      if (done_start) begin
        chk("start_on_done_ignored_busy", busy_o, 0);
        tick();
        chk("start_on_done_ignored_aw", m_awvalid, 0);
      end
    end else begin
      t = 0;
      while (wr_cnt < NR + 1 && t < 1000) begin tick(); t++; end
      chk("kick_write_seen", wr_cnt, NR + 1);
      tick();
      irq_i = 1'b1;
      chk("done_before_early_irq", done_o, 0);
      tick();
      irq_i = 1'b0;
      t = 0;
      while (!done_o && t < 50) begin tick(); t++; end
      chk("done_after_early_irq", done_o, 1);
      chk("kick_resp_before_done", b_cnt, NR + 1);
      chk("busy_at_done", busy_o, 0);
      chk("err_at_done", err_o, err_exp);
      tick();
      chk("done_single_cycle", done_o, 0);
    end
    chk("no_missing_writes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [NR*32-1:0] regs;
    int t;
    repeat (2) tick();
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_err", err_o, 0);
    chk("reset_awvalid", m_awvalid, 0);
    chk("reset_wvalid", m_wvalid, 0);
    chk("reset_bready", m_bready, 0);
    chk("reset_arvalid", m_arvalid, 0);
    chk("reset_araddr", m_araddr, 0);
    chk("reset_rready", m_rready, 1);
    rst = 1'b0;
    tick();

    // zero-wait slave, fixed words, start during done
    run({32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, -1, 0, 0, 1'b0, 1'b1);

    // AW stalled three cycles while W is accepted immediately
    aw_hold = 3;
    run(rand_regs(), -1, 0, 0, 1'b0, 1'b0);

    // SLVERR on the second write, then a clean run that must clear err_o
    run(rand_regs(), 1, 0, 0, 1'b0, 1'b0);
    run(rand_regs(), -1, 0, 0, 1'b0, 1'b0);

    // interrupt pulse while the kick response is still outstanding
    run(rand_regs(), -1, 1, 0, 1'b0, 1'b0);

    // restart attempt mid-run with different words
    run(rand_regs(), -1, 0, 1, 1'b1, 1'b0);

    // reset asserted while the third write's AW is stalled
    b_delay = 0; err_at = -1; b_cnt = 0; wr_cnt = 0;
    regs = rand_regs();
    push_expected(regs);
    regs_i = regs;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    t = 0;
    while (wr_cnt < 2 && t < 200) begin tick(); t++; end
    chk("two_writes_before_reset", wr_cnt, 2);
    aw_hold = 50;
    repeat (3) tick();
    chk("third_aw_pending", m_awvalid, 1);
    rst = 1'b1;
    #1;
    chk("async_reset_awvalid", m_awvalid, 0);
    chk("async_reset_wvalid", m_wvalid, 0);
    chk("async_reset_busy", busy_o, 0);
    chk("async_reset_bready", m_bready, 0);
    tick();
    tick();
    exp_q.delete();
    act_aw_q.delete();
    act_w_q.delete();
    aw_hold = 0;
    rst = 1'b0;
    tick();
    chk("no_done_after_reset", done_o, 0);
    run(rand_regs(), -1, 0, 0, 1'b0, 1'b0);

    // randomised slave timing, errors and interrupt placement
    rand_mode = 1'b1;
    for (int r = 0; r < 10; r++) begin
      run(rand_regs(), int'($urandom_range(0, NR + 1)) - 1, int'($urandom_range(0, 1)),
          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
